// File: rtl/vector_order_if.sv
// Handshake bundle for the vector_order permutation unit: input vector with
// mode/valid qualifiers and the registered, reordered result.
interface vector_order_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] a;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] b;
    logic             out_valid;

    modport master (output a, output mode, output in_valid, input b, input out_valid);
    modport slave  (input a, input mode, input in_valid, output b, output out_valid);
endinterface

// File: rtl/vector_order.sv
// Registered bit-order permutation: full reverse, pass, group-order reverse
// or in-group reverse, selected per vector by mode, with one cycle of latency.
module vector_order #(
    parameter int WIDTH = 4,
    parameter int GROUP = 2
) (
    input  logic          clk,
    input  logic          rst,
    vector_order_if.slave bus
);
    // Guarded copies keep the index arithmetic legal while the check below fires.
    localparam int G_SAFE = (GROUP > 0) ? GROUP : 1;
    localparam int NGRP   = WIDTH / G_SAFE;

    generate
        if (WIDTH < 1 || GROUP < 1 || (WIDTH % G_SAFE) != 0) begin : g_bad_cfg
            $error("vector_order: WIDTH must be >= 1 and GROUP must divide WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_grp_rev;
    logic [WIDTH-1:0] w_in_grp_rev;
    logic [WIDTH-1:0] w_perm;
    logic [WIDTH-1:0] r_b;
    logic             r_out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            localparam int K = gi / G_SAFE;
            localparam int J = gi % G_SAFE;
            assign w_rev[gi]        = bus.a[WIDTH-1-gi];
            assign w_grp_rev[gi]    = bus.a[(NGRP-1-K)*G_SAFE + J];
            assign w_in_grp_rev[gi] = bus.a[K*G_SAFE + G_SAFE-1-J];
        end
    endgenerate

    always_comb begin
        w_perm = bus.a;
        case (bus.mode)
            2'd0:    w_perm = w_rev;
            2'd1:    w_perm = bus.a;
            2'd2:    w_perm = w_grp_rev;
            default: w_perm = w_in_grp_rev;
        endcase
    end

    // b only loads on valid vectors; out_valid tracks in_valid every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_b <= w_perm;
            end
        end
    end

    assign bus.b         = r_b;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_vector_order.sv
// Self-checking bench for vector_order: a 4-bit/GROUP=2 instance and an
// 8-bit/GROUP=4 instance, table vectors plus reset/hold/mode-switch sequences.
module tb_vector_order;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_order_if #(.WIDTH(4)) if4 ();
    vector_order_if #(.WIDTH(8)) if8 ();

    vector_order #(.WIDTH(4), .GROUP(2)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    vector_order #(.WIDTH(8), .GROUP(4)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic [3:0] a;
        logic [1:0] mode;
        logic [3:0] b;
    } vec4_t;

    typedef struct {
        logic [7:0] a;
        logic [1:0] mode;
        logic [7:0] b;
    } vec8_t;

    typedef struct {
        logic [7:0] b;
        logic       v;
        string      name;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   n_total = 0;
    int   n_pass  = 0;

    vec4_t tab4[12];
    vec8_t tab8[12];

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic pop_check(input bit use8);
        exp_t       e;
        logic [7:0] got_b;
        logic       got_v;
        n_total++;
        if (use8) begin
            got_b = if8.b;
            got_v = if8.out_valid;
        end else begin
            got_b = {4'b0000, if4.b};
            got_v = if4.out_valid;
        end
        if ((use8 ? q8.size() : q4.size()) == 0) begin
            $display("FAIL scoreboard_empty dut%0d: got b=%h v=%b, required a queued expectation",
                     use8 ? 8 : 4, got_b, got_v);
            return;
        end
        e = use8 ? q8.pop_front() : q4.pop_front();
        if (got_b === e.b && got_v === e.v) begin
            n_pass++;
            $display("ok   %s: b=%h v=%b", e.name, got_b, got_v);
        end else begin
            $display("FAIL %s: got b=%h v=%b, required b=%h v=%b", e.name, got_b, got_v, e.b, e.v);
        end
    endtask

    task automatic drive4(input logic r, input logic [3:0] a, input logic [1:0] m, input logic v,
                          input logic [3:0] eb, input logic ev, input string name);
        exp_t e;
        @(negedge clk);
        rst = r; if4.a = a; if4.mode = m; if4.in_valid = v;
        e.b = {4'b0000, eb}; e.v = ev; e.name = name;
        q4.push_back(e);
        @(posedge clk); #1;
        pop_check(1'b0);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [1:0] m,
                          input logic [7:0] eb, input string name);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; if8.a = a; if8.mode = m; if8.in_valid = 1'b1;
        e.b = eb; e.v = 1'b1; e.name = name;
        q8.push_back(e);
        @(posedge clk); #1;
        pop_check(1'b1);
    endtask

    initial begin
        tab4[0]  = '{4'b1011, 2'd0, 4'b1101};
        tab4[1]  = '{4'b1011, 2'd1, 4'b1011};
        tab4[2]  = '{4'b1011, 2'd2, 4'b1110};
        tab4[3]  = '{4'b1011, 2'd3, 4'b0111};
        tab4[4]  = '{4'b0110, 2'd0, 4'b0110};
        tab4[5]  = '{4'b0110, 2'd1, 4'b0110};
        tab4[6]  = '{4'b0110, 2'd2, 4'b1001};
        tab4[7]  = '{4'b0110, 2'd3, 4'b1001};
        tab4[8]  = '{4'b1000, 2'd0, 4'b0001};
        tab4[9]  = '{4'b1000, 2'd2, 4'b0010};
        tab4[10] = '{4'b1000, 2'd3, 4'b0100};
        tab4[11] = '{4'b0000, 2'd0, 4'b0000};

        tab8[0]  = '{8'hA1, 2'd0, 8'h85};
        tab8[1]  = '{8'hA1, 2'd1, 8'hA1};
        tab8[2]  = '{8'hA1, 2'd2, 8'h1A};
        tab8[3]  = '{8'hA1, 2'd3, 8'h58};
        tab8[4]  = '{8'h3C, 2'd0, 8'h3C};
        tab8[5]  = '{8'h3C, 2'd2, 8'hC3};
        tab8[6]  = '{8'h3C, 2'd3, 8'hC3};
        tab8[7]  = '{8'h01, 2'd0, 8'h80};
        tab8[8]  = '{8'h01, 2'd2, 8'h10};
        tab8[9]  = '{8'h01, 2'd3, 8'h08};
        tab8[10] = '{8'hFF, 2'd0, 8'hFF};
        tab8[11] = '{8'h12, 2'd1, 8'h12};

        if4.a = '0; if4.mode = '0; if4.in_valid = 1'b0;
        if8.a = '0; if8.mode = '0; if8.in_valid = 1'b0;

        // Reset with valid input active, then release.
        drive4(1'b1, 4'b1111, 2'd0, 1'b1, 4'b0000, 1'b0, "reset_edge1");
        drive4(1'b1, 4'b1111, 2'd0, 1'b1, 4'b0000, 1'b0, "reset_edge2");
        drive4(1'b0, 4'b1111, 2'd0, 1'b1, 4'b1111, 1'b1, "reset_release");

        // Mode 0: a held ten cycles, then a new vector.
        for (int i = 0; i < 10; i++)
            drive4(1'b0, 4'b1011, 2'd0, 1'b1, 4'b1101, 1'b1, "mode0_hold1011");
        drive4(1'b0, 4'b0011, 2'd0, 1'b1, 4'b1100, 1'b1, "mode0_0011");

        for (int i = 0; i < 12; i++)
            drive4(1'b0, tab4[i].a, tab4[i].mode, 1'b1, tab4[i].b, 1'b1,
                   $sformatf("tab4[%0d]_m%0d", i, tab4[i].mode));

        // Hold while in_valid is low, then back-to-back mode switches.
        drive4(1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 1'b1, "hold_load");
        for (int i = 0; i < 3; i++)
            drive4(1'b0, 4'b0110, 2'd2, 1'b0, 4'b1000, 1'b0, "hold_invalid");
        drive4(1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 1'b1, "switch_m0");
        drive4(1'b0, 4'b0001, 2'd1, 1'b1, 4'b0001, 1'b1, "switch_m1");
        drive4(1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 1'b1, "switch_m0b");

        // Reset mid-stream discards the in-flight vector.
        drive4(1'b0, 4'b1011, 2'd0, 1'b1, 4'b1101, 1'b1, "midrst_pre");
        drive4(1'b1, 4'b0011, 2'd0, 1'b1, 4'b0000, 1'b0, "midrst_assert");
        drive4(1'b0, 4'b0011, 2'd0, 1'b1, 4'b1100, 1'b1, "midrst_fresh");

        @(negedge clk); if4.in_valid = 1'b0;

        for (int i = 0; i < 12; i++)
            drive8(tab8[i].a, tab8[i].mode, tab8[i].b,
                   $sformatf("tab8[%0d]_m%0d", i, tab8[i].mode));

        // Mode 3 followed by mode 2 must equal a full reverse.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] x;
            logic [7:0] mid;
            x = 8'($urandom_range(0, 255));
            drive8(x, 2'd1, x, "compose_pass");
            @(negedge clk);
            if8.a = x; if8.mode = 2'd3; if8.in_valid = 1'b1;
            @(posedge clk); #1;
            mid = if8.b;
            drive8(mid, 2'd2, rev8(x), $sformatf("compose_%h", x));
        end

        n_total++;
        if (q4.size() == 0 && q8.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d/%0d left, required 0/0", q4.size(), q8.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vector_order.md
# vector_order

Registered bit-order permutation unit. It takes a WIDTH-bit vector `a` and drives `b` with a reordered copy: full bit reversal, pass-through, group-order reversal, or bit reversal within each group. It sits in datapaths that must convert between MSB-first and LSB-first conventions, for example serializer front-ends and bus endianness adapters. Default configuration is 4-bit bit reversal, so 4'b1011 becomes 4'b1101.

## Interface
- `WIDTH`, default 4: vector width; must be ≥1.
- `GROUP`, default 2: group size for modes 2 and 3; must divide WIDTH exactly. An illegal value is an elaboration error.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-high.
- `a`  in  WIDTH: input vector.
- `b`  out  WIDTH: reordered output, registered.
- `mode`  in  2: permutation select, sampled together with `a`.
- `in_valid`  in  1: qualifies `a` and `mode`.
- `out_valid`  out  1: `b` holds a result from a valid input.
- Tie-off: with `mode`=0 and `in_valid`=1 tied, the block is a plain registered 4-bit reverser.

## Operation
- Mode 0, full reverse: b[i] = a[WIDTH-1-i] for all i.
- Mode 1, pass: b = a.
- Mode 2, group-order reverse: group k is bits [k*GROUP+GROUP-1 : k*GROUP]. Output group k = input group (WIDTH/GROUP-1-k). Bit order inside each group is kept.
- Mode 3, in-group reverse: each group is bit-reversed in place and group positions are unchanged.
- Modes 2 and 3 compose to mode 0: applying mode 2 to the result of mode 3 gives the mode-0 result.
- GROUP=WIDTH: mode 2 equals pass and mode 3 equals full reverse.
- GROUP=1: mode 2 equals full reverse and mode 3 equals pass.
- WIDTH=1: every mode is identity.
- No arithmetic is performed. The permutation is pure wiring into one register stage, with no bits dropped or added.
- `in_valid`=0: `b` holds its previous value and `out_valid` falls to 0 on that edge.

## Timing
- Latency: 1 cycle. `a`, `mode` and `in_valid` are sampled at rising edge N, and `b` and `out_valid` update after edge N.
- Throughput: one vector per cycle. There is no backpressure.
- Reset: when `rst`=1 at an edge, `b`=0 and `out_valid`=0 after that edge. Reset overrides `in_valid`.
- Reset mid-stream: the in-flight vector is discarded. The first edge with `rst`=0 and `in_valid`=1 produces a fresh result on the following cycle.
- A `mode` change between consecutive valid cycles takes effect on that cycle's vector only. There is no pipeline mixing.
- Before the first reset, outputs are undefined. The bench must apply reset first.

## Test plan
- Reset: assert `rst` for 2 edges with `a`=4'b1111 and `in_valid`=1 -> `b`=4'b0000 and `out_valid`=0. Release reset -> next edge gives `b`=4'b1111 (mode 0).
- Mode 0 sequence: `a`=4'b1011, then 4'b0011 ten cycles later -> `b`=4'b1101 one cycle after the first, then `b`=4'b1100. `out_valid`=1 throughout.
- Mode 2 (GROUP=2): `a`=4'b1011 -> `b`=4'b1110.
- Mode 3 (GROUP=2): `a`=4'b1011 -> `b`=4'b0111.
- Mode 1: `a`=4'b1011 -> `b`=4'b1011.
- Hold and mode switch: valid `a`=4'b0001 in mode 0 -> `b`=4'b1000. Then drop `in_valid` for 3 cycles while `a`=4'b0110 -> `b` stays 4'b1000 and `out_valid`=0. Then switch mode 0->1->0 on back-to-back valid vectors 4'b0001, 4'b0001, 4'b0001 -> `b` = 4'b1000, 4'b0001, 4'b1000.
- Parameter sweep (WIDTH=8, GROUP=4): mode 0 on 8'hA1 -> 8'h85. Mode 2 on 8'hA1 -> 8'h1A. Mode 3 on 8'hA1 -> 8'h58.
